mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//   Iterative multi-cycle multiply/divide unit that replaces the single-step MUL path feeding ZHI/ZLO.
//   Operand a comes from the Y register and operand b from the bus; results land in the zhi/zlo regs.
//   Control logic drives it with a start/busy/done handshake instead of a fixed T-step.
//   Adds: parametrised width, DIV, signed/unsigned mode, divide-by-zero flag.
// PARAMETERS
//   WIDTH   32     operand width; zhi/zlo are each WIDTH bits; WIDTH >= 4
//   OP_MUL  4'd12  op code selecting multiply (same code as existing Control_Signals MUL)
//   OP_DIV  4'd13  op code selecting divide
// PORTS
//   clk          in   1      clock, all state changes on posedge
//   clr          in   1      synchronous active-high reset
//   start        in   1      request; sampled on posedge only when unit accepts (see below)
//   op           in   4      OP_MUL or OP_DIV; any other code with start -> request ignored
//   sgn          in   1      1 = two's-complement operands, 0 = unsigned
//   a            in   WIDTH  multiplicand / dividend (Y register)
//   b            in   WIDTH  multiplier / divisor (bus)
//   busy         out  1      operation in progress
//   done         out  1      one-cycle pulse, zhi/zlo valid and updated
//   div_by_zero  out  1      valid with done; 1 = last DIV had b == 0
//   zhi          out  WIDTH  MUL: product[2W-1:W]; DIV: remainder
//   zlo          out  WIDTH  MUL: product[W-1:0];  DIV: quotient
// BEHAVIOUR
//   Reset (clr=1 at posedge): state IDLE; busy=0, done=0, div_by_zero=0, zhi=0, zlo=0;
//     aborts any operation in flight, no done is produced for it. clr has priority over start.
//   FSM: IDLE -> RUN -> FIX -> DONE -> IDLE.
//     IDLE/DONE: start=1 with valid op -> RUN (DONE accepts back-to-back start); else -> IDLE.
//     RUN: one iteration per clock, counter loaded with WIDTH, -> FIX when counter reaches 0.
//     FIX: sign correction, result registered into zhi/zlo, -> DONE.
//     DONE: done=1 for exactly this one cycle.
//   Acceptance edge E: a, b, op, sgn captured; later input changes have no effect.
//   busy=1 in RUN and FIX, 0 in IDLE and DONE; start while busy is ignored (not queued).
//   Latency: zhi/zlo/div_by_zero update and done rises on edge E+WIDTH+2 (E+34 for WIDTH=32).
//   zhi/zlo hold their value until the next done or clr.
//   MUL: full 2W-bit product a*b, signed if sgn else unsigned; radix-2 shift-add/Booth on
//     magnitudes or sign-extended W+1-bit operands. No overflow possible.
//   DIV: restoring division on magnitudes; if sgn, quotient negated when signs of a and b differ,
//     remainder takes sign of a (truncation toward zero); a == q*b + r always holds mod 2^W.
//   DIV signed a = 2^(W-1) (most negative), b = -1: zlo = 2^(W-1) (wraps), zhi = 0, no flag.
//   DIV b == 0: detected at E; skips RUN (E -> FIX -> DONE), done on edge E+2;
//     div_by_zero=1, zlo = all ones, zhi = a. div_by_zero cleared on next accepted start.
//   div_by_zero is 0 for every MUL result.
// TESTING (WIDTH=32)
//   sgn=1 MUL a=2 b=4 -> done exactly 34 edges after start, zhi=0, zlo=8, busy high 33 cycles.
//   MUL sgn=1 a=-3 b=7 -> zhi=FFFFFFFF zlo=FFFFFFEB;
//     sgn=0 a=b=FFFFFFFF -> zhi=FFFFFFFE zlo=00000001.
//   DIV sgn=1 a=-7 b=2 -> zlo=FFFFFFFD zhi=FFFFFFFF;
//     sgn=0 a=100 b=7 -> zlo=14 zhi=2; sgn=1 a=80000000 b=FFFFFFFF -> zlo=80000000 zhi=0.
//   DIV a=5 b=0 -> done on edge E+2, div_by_zero=1, zlo=FFFFFFFF, zhi=5; following MUL clears flag.
//   start pulsed again at E+5 with new operands -> ignored, first result unaffected;
//     start held in DONE cycle -> second op accepted, its done 34 edges later.
//   clr at E+10 of a MUL -> busy=0, zhi=zlo=0 next cycle, no done pulse; op code 4'd3 with start
//     -> busy stays 0.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply / restoring divide unit with start/busy/done handshake.
// Results land in zhi/zlo; the handshake outputs trail the FSM state by one register stage.
module mul_div_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter logic [3:0]  OP_MUL = 4'd12,
  parameter logic [3:0]  OP_DIV = 4'd13
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] zhi,
  output logic [WIDTH-1:0] zlo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               dz;
  logic               neg_q;
  logic               neg_r;

  logic               op_ok;
  logic               accept;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;

  assign op_ok  = (op == OP_MUL) || (op == OP_DIV);
  assign accept = start && op_ok && ((state == IDLE) || (state == DONE));

  // Operands are reduced to magnitudes at acceptance; signs are restored in FIX.
  assign a_neg  = sgn & a[WIDTH-1];
  assign b_neg  = sgn & b[WIDTH-1];
  assign a_mag  = a_neg ? (~a + 1'b1) : a;
  assign b_mag  = b_neg ? (~b + 1'b1) : b;

  // One shift-add step: hi accumulates, lo shifts out the multiplier bits.
  assign mul_sum  = {1'b0, hi} + ({1'b0, opnd} & {(WIDTH + 1){lo[0]}});

  // One restoring step: partial remainder in hi, quotient bits shift into lo.
  assign div_sh   = {hi, lo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd};
  assign div_ge   = ~div_diff[WIDTH];

  assign prod     = {hi, lo};

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      dz          <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      zhi         <= '0;
      zlo         <= '0;
    end else begin
      done <= 1'b0;
      busy <= (state == RUN) || (state == FIX);

      case (state)
        RUN: begin
          if (is_div) begin
            hi <= div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], div_ge};
          end else begin
            {hi, lo} <= {mul_sum, lo[WIDTH-1:1]};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (dz) begin
            hi <= lo;
            lo <= '1;
          end else if (is_div) begin
            lo <= neg_q ? (~lo + 1'b1) : lo;
            hi <= neg_r ? (~hi + 1'b1) : hi;
          end else if (neg_q) begin
            {hi, lo} <= ~prod + 1'b1;
          end
          state <= DONE;
        end
        DONE: begin
          zhi         <= hi;
          zlo         <= lo;
          done        <= 1'b1;
          div_by_zero <= dz;
          state       <= IDLE;
        end
        default: ;
      endcase

      // Acceptance overrides the IDLE/DONE fall-through and captures all operands.
      if (accept) begin
        if (state == IDLE) div_by_zero <= 1'b0;
        is_div <= (op == OP_DIV);
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        hi     <= '0;
        cnt    <= CW'(WIDTH);
        if ((op == OP_DIV) && (b == '0)) begin
          dz    <= 1'b1;
          lo    <= a;
          state <= FIX;
        end else begin
          dz    <= 1'b0;
          lo    <= (op == OP_DIV) ? a_mag : b_mag;
          opnd  <= (op == OP_DIV) ? b_mag : a_mag;
          state <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed table, random ops against an arithmetic model,
// and hand-written handshake corner cases (ignored restart, back-to-back, abort, bad op).
module tb_mul_div_unit;

  localparam int unsigned W = 32;
  localparam logic [3:0] OP_MUL = 4'd12;
  localparam logic [3:0] OP_DIV = 4'd13;

  logic         clk = 1'b0;
  logic         clr;
  logic         start;
  logic [3:0]   op;
  logic         sgn;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] zhi;
  logic [W-1:0] zlo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W), .OP_MUL(OP_MUL), .OP_DIV(OP_DIV)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .sgn(sgn), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .zhi(zhi), .zlo(zlo)
  );

  typedef struct {
    logic [3:0]  op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ezhi;
    logic [31:0] ezlo;
    logic        edz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
  function automatic logic [64:0] model(input logic [3:0] o, input logic s,
                                        input logic [31:0] x, input logic [31:0] y);
    longint      sx;
    longint      sy;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    sx = s ? longint'($signed(x)) : longint'({32'b0, x});
    sy = s ? longint'($signed(y)) : longint'({32'b0, y});
    if (o == OP_MUL) begin
      p = 64'(sx * sy);
      return {1'b0, p};
    end
    if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
    q = 64'(sx / sy);
    r = 64'(sx % sy);
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  task automatic issue(input logic [3:0] o, input logic s, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; sgn = s; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges until done is seen (at least one edge), bounded.
  task automatic wait_done(output int lat, output int bcyc);
    lat = 0;
    bcyc = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (busy === 1'b1) bcyc++;
    end while (done !== 1'b1 && lat < 100);
  endtask

  task automatic run_check(input string name, input logic [3:0] o, input logic s,
                           input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    int lat;
    int bc;
    int elat;
    elat = (o == OP_DIV && y == 32'd0) ? 2 : W + 2;
    issue(o, s, x, y);
    wait_done(lat, bc);
    chk({name, "_lat"}, 64'(lat), 64'(elat));
    chk({name, "_busy"}, 64'(bc), 64'(elat - 1));
    chk({name, "_zhi"}, 64'(zhi), 64'(ehi));
    chk({name, "_zlo"}, 64'(zlo), 64'(elo));
    chk({name, "_dz"}, 64'(div_by_zero), 64'(edz));
    @(posedge clk);
    #1 chk({name, "_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    logic [64:0] m;
    logic [3:0]  ro;
    logic        rs;
    logic [31:0] rx;
    logic [31:0] ry;
    int          lat;
    int          bc;
    int          cnt;

    vecs[0] = '{OP_MUL, 1'b1, 32'd2,         32'd4,         32'd0,         32'd8,         1'b0};
    vecs[1] = '{OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2] = '{OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[3] = '{OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4] = '{OP_DIV, 1'b0, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[5] = '{OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
    vecs[6] = '{OP_DIV, 1'b0, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{OP_MUL, 1'b0, 32'd6,         32'd7,         32'd0,         32'd42,        1'b0};
    vecs[8] = '{OP_DIV, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[9] = '{OP_MUL, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0};

    clr = 1'b1; start = 1'b0; op = 4'd0; sgn = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_dz", 64'(div_by_zero), 64'(0));
    chk("rst_zhi", 64'(zhi), 64'(0));
    chk("rst_zlo", 64'(zlo), 64'(0));
    clr = 1'b0;

    for (int i = 0; i < 10; i++)
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b,
                vecs[i].ezhi, vecs[i].ezlo, vecs[i].edz);

    for (int i = 0; i < 40; i++) begin
      ro = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
      rs = 1'($urandom_range(0, 1));
      rx = $urandom;
      case ($urandom_range(0, 5))
        0: ry = 32'd0;
        1: ry = 32'hFFFF_FFFF;
        2: ry = 32'($urandom_range(1, 9));
        default: ry = $urandom;
      endcase
      if (i % 7 == 3) rx = 32'h8000_0000;
      m = model(ro, rs, rx, ry);
      run_check($sformatf("rnd%0d", i), ro, rs, rx, ry, m[63:32], m[31:0], m[64]);
    end

    // Restart at E+5 with new operands must be ignored.
    issue(OP_MUL, 1'b0, 32'd1000, 32'd3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'd7; b = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bc);
    chk("restart_lat", 64'(lat), 64'(W + 2 - 5));
    chk("restart_zhi", 64'(zhi), 64'(0));
    chk("restart_zlo", 64'(zlo), 64'(3000));
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (busy === 1'b1 || done === 1'b1) cnt++;
    end
    chk("restart_no_second", 64'(cnt), 64'(0));

    // Start held through the DONE cycle: second op accepted back-to-back.
    @(negedge clk);
    start = 1'b1; op = OP_MUL; sgn = 1'b1; a = 32'hFFFF_FFFD; b = 32'd7;
    @(posedge clk);
    #1 begin op = OP_DIV; sgn = 1'b0; a = 32'd100; b = 32'd7; end
    wait_done(lat, bc);
    start = 1'b0;
    chk("b2b_first_lat", 64'(lat), 64'(W + 2));
    chk("b2b_first_zhi", 64'(zhi), 64'(32'hFFFF_FFFF));
    chk("b2b_first_zlo", 64'(zlo), 64'(32'hFFFF_FFEB));
    wait_done(lat, bc);
    chk("b2b_second_lat", 64'(lat), 64'(W + 2));
    chk("b2b_second_zhi", 64'(zhi), 64'(2));
    chk("b2b_second_zlo", 64'(zlo), 64'(14));
    @(posedge clk);

    // clr at E+10 aborts a MUL without a done pulse.
    issue(OP_MUL, 1'b1, 32'd2, 32'd4);
    repeat (9) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_zhi", 64'(zhi), 64'(0));
    chk("abort_zlo", 64'(zlo), 64'(0));
    clr = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done === 1'b1 || busy === 1'b1) cnt++;
    end
    chk("abort_no_done", 64'(cnt), 64'(0));

    // Unknown op code is ignored.
    issue(4'd3, 1'b0, 32'd9, 32'd9);
    cnt = 0;
    repeat (6) begin
      @(posedge clk);
      #1 if (busy === 1'b1 || done === 1'b1) cnt++;
    end
    chk("badop_busy", 64'(cnt), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
